// File: rtl/digest_reader.sv
// ---------------------------------------------------------------------------
// digest_reader
// Reads NUM_WORDS consecutive 32-bit words from a synchronous data memory
// (1-cycle read latency), starting at word index BASE_ADDR, and streams each
// word out as four bytes, most significant byte first, over a valid/ready
// byte interface. A one-cycle done pulse marks the end of a job.
//
// Parameters
//   BASE_ADDR  word index of the first word read (wraps modulo 2^ADDR_W)
//   NUM_WORDS  words per job, 1..256
//   ADDR_W     width of the word address bus
//
// Ports
//   clk        single clock, rising edge
//   reset      synchronous, active-high reset
//   start      job request, honoured only while idle
//   busy       high whenever a job is in progress (any state but IDLE)
//   done       one-cycle pulse at job completion
//   mem_rd_en  memory read strobe
//   mem_addr   memory word address (holds its value between strobes)
//   mem_rdata  memory read data, valid the cycle after mem_rd_en
//   out_data   streamed byte
//   out_valid  out_data is valid
//   out_ready  sink accepts the byte when out_valid is also high
//   out_last   final byte of the job, qualified by out_valid
// ---------------------------------------------------------------------------
module digest_reader #(
    parameter int BASE_ADDR = 0,
    parameter int NUM_WORDS = 8,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    typedef enum logic [2:0] {IDLE, REQ, CAPTURE, SEND, DONE} state_t;

    state_t      state;
    logic [7:0]  word_cnt;
    logic [1:0]  byte_cnt;
    logic [31:0] shift;
    logic        last_word;

    assign last_word = (word_cnt == 8'(NUM_WORDS - 1));

    // Word address of job word idx; the cast keeps only ADDR_W bits so the
    // address wraps around the top of memory.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [7:0] idx);
        return ADDR_W'(BASE_ADDR + int'(idx));
    endfunction

    // All outputs are registered and updated together with the state, so
    // each output already carries the value belonging to the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            shift     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= REQ;
                        word_cnt  <= '0;
                        busy      <= 1'b1;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= word_addr(8'd0);
                    end
                end

                REQ: begin
                    state     <= CAPTURE;
                    mem_rd_en <= 1'b0;
                end

                CAPTURE: begin
                    state     <= SEND;
                    shift     <= mem_rdata;
                    byte_cnt  <= '0;
                    out_valid <= 1'b1;
                    out_data  <= mem_rdata[31:24];
                    out_last  <= 1'b0;
                end

                SEND: begin
                    // Nothing moves while the sink stalls.
                    if (out_ready) begin
                        shift    <= shift << 8;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (last_word) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state     <= REQ;
                                word_cnt  <= word_cnt + 8'd1;
                                mem_rd_en <= 1'b1;
                                mem_addr  <= word_addr(word_cnt + 8'd1);
                            end
                        end else begin
                            out_data <= shift[23:16];
                            out_last <= (byte_cnt == 2'd2) && last_word;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    mem_rd_en <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digest_reader.sv
// ---------------------------------------------------------------------------
// tb_digest_reader
// Three digest_reader instances share one clock, reset and memory array:
//   dut 0: BASE_ADDR=0,    NUM_WORDS=8
//   dut 1: BASE_ADDR=1022, NUM_WORDS=4 (address wrap)
//   dut 2: BASE_ADDR=0,    NUM_WORDS=1
// A table of job records is replayed against them; each job is checked
// against a byte/address list built directly from the memory contents.
// ---------------------------------------------------------------------------
module tb_digest_reader;

    logic            clk = 1'b0;
    logic            reset;
    logic [2:0]      start_v;
    logic [2:0]      ready_v;
    logic [2:0][31:0] rdata_v;
    wire  [2:0]      busy_v;
    wire  [2:0]      done_v;
    wire  [2:0]      rd_v;
    wire  [2:0][9:0] addr_v;
    wire  [2:0][7:0] data_v;
    wire  [2:0]      valid_v;
    wire  [2:0]      last_v;

    logic [31:0] mem [0:1023];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    digest_reader #(.BASE_ADDR(0), .NUM_WORDS(8), .ADDR_W(10)) dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .mem_rd_en(rd_v[0]), .mem_addr(addr_v[0]),
        .mem_rdata(rdata_v[0]), .out_data(data_v[0]), .out_valid(valid_v[0]),
        .out_ready(ready_v[0]), .out_last(last_v[0]));

    digest_reader #(.BASE_ADDR(1022), .NUM_WORDS(4), .ADDR_W(10)) dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .mem_rd_en(rd_v[1]), .mem_addr(addr_v[1]),
        .mem_rdata(rdata_v[1]), .out_data(data_v[1]), .out_valid(valid_v[1]),
        .out_ready(ready_v[1]), .out_last(last_v[1]));

    digest_reader #(.BASE_ADDR(0), .NUM_WORDS(1), .ADDR_W(10)) dut2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .mem_rd_en(rd_v[2]), .mem_addr(addr_v[2]),
        .mem_rdata(rdata_v[2]), .out_data(data_v[2]), .out_valid(valid_v[2]),
        .out_ready(ready_v[2]), .out_last(last_v[2]));

    // Synchronous memory, one read port per instance, 1-cycle latency.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++)
            if (rd_v[d]) rdata_v[d] <= mem[addr_v[d]];
    end

    function automatic int nw_of(input int d);
        case (d)
            0: return 8;
            1: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int base_of(input int d);
        return (d == 1) ? 1022 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // sel 0: fixed digest words, 1: random words for the job, 2: "hell" word.
    task automatic load_data(input int sel, input int d);
        logic [31:0] fixed [8];
        fixed = '{32'hb94d27b9, 32'h934d3e08, 32'ha52e52d7, 32'hda7dabfa,
                  32'hc484efe3, 32'h7a5380ee, 32'h9088f7ac, 32'he2efcde9};
        case (sel)
            0: for (int i = 0; i < 8; i++) mem[i] = fixed[i];
            1: for (int w = 0; w < nw_of(d); w++) mem[(base_of(d) + w) % 1024] = $urandom;
            default: mem[0] = 32'h68656c6c;
        endcase
    endtask

    // One full job on instance d. mode 0: ready always high, 1: toggling,
    // 2: random. spam keeps start high for the whole job.
    task automatic run_job(input int d, input int mode, input bit spam);
        logic [7:0]  exp_q [$];
        int          addr_q [$];
        logic [31:0] wv;
        int nw, cyc, nbytes, nrd, done_cyc, first_valid, last_cyc, last_addr;
        bit got_done, prev_stall, rdy;
        logic [7:0] prev_data;
        logic prev_last;

        nw = nw_of(d);
        for (int w = 0; w < nw; w++) begin
            addr_q.push_back((base_of(d) + w) % 1024);
            wv = mem[(base_of(d) + w) % 1024];
            for (int b = 0; b < 4; b++) exp_q.push_back(8'(wv >> (24 - 8 * b)));
        end
        nbytes = 0; nrd = 0; done_cyc = -1; first_valid = -1; last_cyc = -1;
        last_addr = 0; got_done = 0; prev_stall = 0; prev_data = '0; prev_last = 0;

        @(posedge clk); #1;
        start_v[d] = 1'b1;
        ready_v[d] = 1'b1;
        cyc = 0;
        while (!got_done && cyc < 700) begin
            cyc++;
            @(posedge clk); #1;
            start_v[d] = spam;
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 2 == 1);
            else                rdy = 1'($urandom_range(0, 1));
            ready_v[d] = rdy;
            @(negedge clk);

            if (rd_v[d]) begin
                nrd++;
                if (nrd == 1) check("first_rd_cycle", cyc, 1);
                if (addr_q.size() > 0) begin
                    last_addr = addr_q.pop_front();
                    check("mem_addr", addr_v[d], last_addr);
                end else check("rd_count", nrd, nw);
            end else if (nrd > 0) check("addr_hold", addr_v[d], last_addr);

            if (prev_stall) begin
                check("stall_valid", valid_v[d], 1);
                check("stall_data", data_v[d], prev_data);
                check("stall_last", last_v[d], prev_last);
            end

            if (valid_v[d]) begin
                if (first_valid < 0) first_valid = cyc;
                if (rdy) begin
                    nbytes++;
                    if (exp_q.size() > 0) check("out_data", data_v[d], exp_q.pop_front());
                    else check("byte_count", nbytes, 4 * nw);
                    check("out_last", last_v[d], exp_q.size() == 0);
                    if (last_v[d]) last_cyc = cyc;
                end
            end
            prev_stall = valid_v[d] && !rdy;
            prev_data  = data_v[d];
            prev_last  = last_v[d];

            if (done_v[d]) begin
                got_done = 1'b1;
                done_cyc = cyc;
                check("busy_at_done", busy_v[d], 1);
                check("valid_at_done", valid_v[d], 0);
            end
        end

        check("done_seen", got_done, 1);
        check("bytes_total", nbytes, 4 * nw);
        check("rd_pulses", nrd, nw);
        if (mode == 0) begin
            check("first_valid_cycle", first_valid, 3);
            check("last_byte_cycle", last_cyc, 6 * nw);
            check("done_cycle", done_cyc, 6 * nw + 1);
        end

        @(posedge clk); #1;
        start_v[d] = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done_v[d], 0);
        check("idle_busy", busy_v[d], 0);
        check("idle_rd_en", rd_v[d], 0);
        @(posedge clk);
        @(negedge clk);
        check("stays_idle", busy_v[d], 0);
    endtask

    task automatic check_reset_outputs(input int d);
        check("rst_busy", busy_v[d], 0);
        check("rst_done", done_v[d], 0);
        check("rst_rd_en", rd_v[d], 0);
        check("rst_addr", addr_v[d], 0);
        check("rst_valid", valid_v[d], 0);
        check("rst_last", last_v[d], 0);
        check("rst_data", data_v[d], 0);
    endtask

    typedef struct {
        int dut;
        int mode;
        bit spam;
        int data_sel;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [9];
        int   n;

        tbl[0] = '{dut: 0, mode: 0, spam: 0, data_sel: 0};
        tbl[1] = '{dut: 0, mode: 1, spam: 0, data_sel: 0};
        tbl[2] = '{dut: 0, mode: 0, spam: 1, data_sel: 0};
        tbl[3] = '{dut: 0, mode: 2, spam: 0, data_sel: 1};
        tbl[4] = '{dut: 0, mode: 2, spam: 1, data_sel: 1};
        tbl[5] = '{dut: 1, mode: 0, spam: 0, data_sel: 1};
        tbl[6] = '{dut: 1, mode: 1, spam: 0, data_sel: 1};
        tbl[7] = '{dut: 2, mode: 0, spam: 0, data_sel: 2};
        tbl[8] = '{dut: 2, mode: 2, spam: 1, data_sel: 1};

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        reset   = 1'b1;
        start_v = '0;
        ready_v = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_reset_outputs(d);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            load_data(tbl[i].data_sel, tbl[i].dut);
            run_job(tbl[i].dut, tbl[i].mode, tbl[i].spam);
        end

        // Reset after the 10th transferred byte aborts the job.
        load_data(0, 0);
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        ready_v[0] = 1'b1;
        n = 0;
        for (int c = 0; c < 100 && n < 10; c++) begin
            @(posedge clk); #1;
            start_v[0] = 1'b0;
            @(negedge clk);
            if (valid_v[0] && ready_v[0]) n++;
        end
        check("reached_10_bytes", n, 10);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs(0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs(0);
        run_job(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/digest_reader.md
DIGEST_READER -- requirements
Module: digest_reader

Interface
REQ-001 Parameter BASE_ADDR, default 0, SHALL be the data-memory word index of the first word read.
REQ-002 Parameter NUM_WORDS, default 8, SHALL be the number of 32-bit words read per job; legal range 1..256.
REQ-003 Parameter ADDR_W, default 10, SHALL be the width of the word address bus.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-006 start  input  1  SHALL request one readout job when high in IDLE.
REQ-007 busy  output  1  SHALL be high in every state except IDLE.
REQ-008 done  output  1  SHALL be a one-cycle pulse when a job completes.
REQ-009 mem_rd_en  output  1  SHALL be the read strobe to a synchronous data memory with 1-cycle read latency.
REQ-010 mem_addr  output  ADDR_W  SHALL be the word read address.
REQ-011 mem_rdata  input  32  SHALL be the read data, valid the cycle after mem_rd_en.
REQ-012 out_data  output  8  SHALL be the streamed byte.
REQ-013 out_valid  output  1  SHALL mark out_data valid.
REQ-014 out_ready  input  1  SHALL be the sink acceptance; a byte transfers on a cycle with out_valid and out_ready both high.
REQ-015 out_last  output  1  SHALL mark the final byte of the job, qualified by out_valid.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, CAPTURE, SEND, DONE.
REQ-017 IDLE: start high -> REQ with word_cnt=0; start is ignored in all other states.
REQ-018 REQ: mem_rd_en=1 and mem_addr=(BASE_ADDR+word_cnt) truncated to ADDR_W (wraps modulo 2^ADDR_W) for exactly one cycle -> CAPTURE.
REQ-019 CAPTURE: latch mem_rdata into a 32-bit shift register, byte_cnt=0 -> SEND.
REQ-020 SEND: out_valid=1, out_data=shift[31:24] (big-endian, MSB byte first).
REQ-021 SEND: on transfer, shift left 8 and increment byte_cnt; on the transfer with byte_cnt=3, go to DONE if word_cnt=NUM_WORDS-1, else increment word_cnt and go to REQ.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_last and the state SHALL remain unchanged indefinitely.
REQ-023 out_last SHALL be 1 only in SEND with byte_cnt=3 and word_cnt=NUM_WORDS-1.
REQ-024 DONE: done=1 for one cycle -> IDLE; start in this cycle is ignored.
REQ-025 mem_rd_en SHALL be 0 outside REQ; mem_addr SHALL hold its last value when mem_rd_en=0.
REQ-026 Latency with start sampled high in cycle 0 and out_ready held high: mem_rd_en in cycle 1, first out_valid in cycle 3, 6 cycles per word, done in cycle 6*NUM_WORDS+1 (49 for default).
REQ-027 out_valid SHALL never be asserted in IDLE, REQ, CAPTURE or DONE; bubbles between words are permitted.

Reset
REQ-028 reset high at a clock edge SHALL force IDLE, with word_cnt, byte_cnt and the shift register cleared.
REQ-029 While reset is high and in the cycle after: busy=0, done=0, mem_rd_en=0, mem_addr=0, out_valid=0, out_last=0, out_data=0.
REQ-030 Reset mid-job SHALL abort the job with no done pulse; the next start SHALL begin again at BASE_ADDR.

Verification
REQ-031 mem[0..7]=b94d27b9,934d3e08,a52e52d7,da7dabfa,c484efe3,7a5380ee,9088f7ac,e2efcde9 and out_ready=1; pulse start -> 32 bytes b9 4d 27 b9 93 ... cd e9 are streamed, out_last on byte e9 only, done in cycle 49.
REQ-032 Same preload with out_ready toggled 1/0 each cycle -> identical byte sequence, out_data stable whenever stalled, no bytes lost or repeated.
REQ-033 Assert start repeatedly during a job -> exactly one job and one done pulse; mem_rd_en pulses exactly 8 times.
REQ-034 Assert reset after the 10th transferred byte -> outputs at reset values next cycle, no done; a new start streams from byte b9 again.
REQ-035 BASE_ADDR=1022, ADDR_W=10, NUM_WORDS=4 -> mem_addr sequence 1022, 1023, 0, 1.
REQ-036 NUM_WORDS=1 with mem[0]=0x68656c6c -> bytes 68 65 6c 6c, out_last on 6c in cycle 6, done in cycle 7.
